// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 schedule types, constants and sigma helpers.
package sha_pkg;
  localparam int SHA_BLOCK_WORDS = 16;
  typedef logic [31:0] word_t;
  typedef word_t [SHA_BLOCK_WORDS-1:0] block_t;
  typedef enum logic {IDLE, RUN} sched_state_t;
  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t sig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t sig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  // history keeps the oldest word at the top index, so a fresh block loads reversed
  function automatic block_t load_hist(block_t b);
    block_t r;
    for (int i = 0; i < SHA_BLOCK_WORDS; i++) r[i] = b[SHA_BLOCK_WORDS-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sha_schedule_ctrl_if.sv
// sha_schedule_ctrl_if: block-in / word-out handshake bundle of the schedule controller.
interface sha_schedule_ctrl_if;
  import sha_pkg::*;
  logic blk_valid_i;
  logic blk_ready_o;
  block_t blk_i;
  logic w_valid_o;
  logic w_ready_i;
  word_t w_o;
  logic [5:0] round_o;
  logic last_o;
  modport master (
    output blk_valid_i, blk_i, w_ready_i,
    input blk_ready_o, w_valid_o, w_o, round_o, last_o
  );
  modport slave (
    input blk_valid_i, blk_i, w_ready_i,
    output blk_ready_o, w_valid_o, w_o, round_o, last_o
  );
endinterface

// File: rtl/sha_message_expander_round.sv
// sha_message_expander_round: one SHA-256 expansion step; h[0] newest, h[15] oldest.
module sha_message_expander_round import sha_pkg::*; (
  input block_t h,
  output word_t w
);
  assign w = sig1(h[1]) + h[6] + sig0(h[14]) + h[15];
endmodule

// File: rtl/sha_schedule_ctrl.sv
// sha_schedule_ctrl: streams NUM_WORDS SHA-256 schedule words per accepted block.
// SHA_SCHED_PREFETCH_EN adds a one-entry pending-block buffer for back-to-back blocks.
module sha_schedule_ctrl import sha_pkg::*; #(
  parameter int NUM_WORDS = 64
) (
  input logic clk,
  input logic rst,
  sha_schedule_ctrl_if.slave bus
);
  sched_state_t state, state_n;
  block_t h;
  word_t nw;
  logic [5:0] cnt;
  logic live, last, xfer, acc, load_in;
`ifdef SHA_SCHED_PREFETCH_EN
  block_t pbuf;
  logic pfull, load_buf, buf_wr;
`endif
  assign last = cnt == 6'(NUM_WORDS - 1);
  assign xfer = bus.w_valid_o && bus.w_ready_i;
  assign acc = bus.blk_valid_i && bus.blk_ready_o;
  assign bus.w_valid_o = state == RUN;
  assign bus.w_o = h[SHA_BLOCK_WORDS-1];
  assign bus.round_o = cnt;
  assign bus.last_o = state == RUN && last;
  // live keeps ready low during reset and raises it on the first edge after release
`ifdef SHA_SCHED_PREFETCH_EN
  assign bus.blk_ready_o = live && (state == IDLE || !pfull);
`else
  assign bus.blk_ready_o = live && state == IDLE;
`endif
  sha_message_expander_round u_exp (.h(h), .w(nw));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    load_in = 1'b0;
`ifdef SHA_SCHED_PREFETCH_EN
    load_buf = 1'b0;
    buf_wr = 1'b0;
`endif
    if (state == IDLE) begin
      load_in = acc;
      state_n = acc ? RUN : IDLE;
    end else if (xfer && last) begin
`ifdef SHA_SCHED_PREFETCH_EN
      load_buf = pfull;
      load_in = acc;
      state_n = (pfull || acc) ? RUN : IDLE;
`else
      state_n = IDLE;
`endif
    end
`ifdef SHA_SCHED_PREFETCH_EN
    buf_wr = acc && state == RUN && !(xfer && last);
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      cnt <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (load_in) begin
        h <= load_hist(bus.blk_i);
        cnt <= '0;
`ifdef SHA_SCHED_PREFETCH_EN
      end else if (load_buf) begin
        h <= load_hist(pbuf);
        cnt <= '0;
`endif
      end else if (xfer) begin
        h <= {h[SHA_BLOCK_WORDS-2:0], nw};
        cnt <= last ? '0 : cnt + 6'd1;
      end
    end
`ifdef SHA_SCHED_PREFETCH_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pbuf <= '0;
      pfull <= 1'b0;
    end else if (load_buf) pfull <= 1'b0;
    else if (buf_wr) begin
      pbuf <= bus.blk_i;
      pfull <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sha_schedule_ctrl.sv
// tb_sha_schedule_ctrl: directed + randomized bench against an array-based SHA-256 schedule model.
module tb_sha_schedule_ctrl;
  import sha_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_w [64];
  logic [31:0] ref_a [64];
  logic [31:0] ref_b [64];
  sha_schedule_ctrl_if bus ();
  sha_schedule_ctrl_if s16 ();
  sha_schedule_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  sha_schedule_ctrl #(.NUM_WORDS(16)) dut16 (.clk(clk), .rst(rst), .bus(s16));
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic fill_ref(input block_t b);
    for (int t = 0; t < 64; t++)
      if (t < 16) ref_w[t] = b[t];
      else ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10)) + ref_w[t-7]
                    + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3)) + ref_w[t-16];
  endtask

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input bit sel, input block_t b);
    int n;
    bit rdy;
    n = 0;
    if (sel) begin s16.blk_i = b; s16.blk_valid_i = 1'b1; end
    else begin bus.blk_i = b; bus.blk_valid_i = 1'b1; end
    do begin
      rdy = sel ? s16.blk_ready_o : bus.blk_ready_o;
      tick();
      n++;
    end while (!rdy && n < 50);
    chk("accept", 32'(rdy), 32'd1);
    s16.blk_valid_i = 1'b0;
    bus.blk_valid_i = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0 from the first valid word, 2: random ready
  task automatic stream(input bit sel, input int nw, input int mode, output int span);
    int idx, cyc, n;
    bit r;
    idx = 0; cyc = 0; n = 0; span = -1;
    while (idx < nw && n < 2000) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (sel) s16.w_ready_i = r; else bus.w_ready_i = r;
      chk("w_valid", 32'(sel ? s16.w_valid_o : bus.w_valid_o), 32'd1);
      chk("w_o", sel ? s16.w_o : bus.w_o, ref_w[idx]);
      chk("round_o", 32'(sel ? s16.round_o : bus.round_o), 32'(idx));
      chk("last_o", 32'(sel ? s16.last_o : bus.last_o), 32'(idx == nw - 1));
      if (r) begin
        if (idx == nw - 1) span = cyc + 1;
        idx++;
      end
      cyc++;
      n++;
      tick();
    end
    chk("stream_done", 32'(idx), 32'(nw));
    bus.w_ready_i = 1'b0;
    s16.w_ready_i = 1'b0;
    chk("idle_after", 32'(sel ? s16.w_valid_o : bus.w_valid_o), 32'd0);
  endtask

  initial begin
    block_t abc, a, b;
    int span, n, idx, gap, other, nacc;
    bit pend;
    bus.blk_valid_i = 1'b0; bus.blk_i = '0; bus.w_ready_i = 1'b0;
    s16.blk_valid_i = 1'b0; s16.blk_i = '0; s16.w_ready_i = 1'b0;
    #1;
    chk("rst_w_valid", 32'(bus.w_valid_o), 32'd0);
    chk("rst_blk_ready", 32'(bus.blk_ready_o), 32'd0);
    chk("rst_w_o", bus.w_o, 32'd0);
    chk("rst_round", 32'(bus.round_o), 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.blk_ready_o), 32'd1);
    chk("ready16_after_rst", 32'(s16.blk_ready_o), 32'd1);
    // "abc" padded block with spec-given expansion words
    abc = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    fill_ref(abc);
    ref_w[16] = 32'h61626380;
    ref_w[17] = 32'h000F0000;
    ref_w[18] = 32'h7DA86405;
    offer(1'b0, abc);
    stream(1'b0, 64, 0, span);
    chk("span_full_rate", 32'(span), 32'd64);
    offer(1'b0, abc);
    stream(1'b0, 64, 1, span);
    chk("span_toggle", 32'(span), 32'd127);
    for (int k = 0; k < 3; k++) begin
      a = rand_block();
      fill_ref(a);
      offer(1'b0, a);
      stream(1'b0, 64, 2, span);
    end
    // NUM_WORDS=16 instance emits the message words unchanged
    a = rand_block();
    fill_ref(a);
    offer(1'b1, a);
    stream(1'b1, 16, 0, span);
    a = rand_block();
    fill_ref(a);
    offer(1'b1, a);
    stream(1'b1, 16, 2, span);
    // asynchronous reset mid-block
    a = rand_block();
    fill_ref(a);
    offer(1'b0, a);
    bus.w_ready_i = 1'b1;
    n = 0;
    while (bus.round_o != 6'd20 && n < 100) begin tick(); n++; end
    chk("mid_round", 32'(bus.round_o), 32'd20);
    chk("mid_word", bus.w_o, ref_w[20]);
    rst = 1'b1;
    #1;
    chk("async_w_valid", 32'(bus.w_valid_o), 32'd0);
    chk("async_blk_ready", 32'(bus.blk_ready_o), 32'd0);
    chk("async_w_o", bus.w_o, 32'd0);
    chk("async_round", 32'(bus.round_o), 32'd0);
    bus.w_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.blk_ready_o), 32'd1);
    chk("post_rst_w_valid", 32'(bus.w_valid_o), 32'd0);
    a = rand_block();
    fill_ref(a);
    offer(1'b0, a);
    stream(1'b0, 64, 0, span);
    // two blocks offered back-to-back with blk_valid_i held high
    a = rand_block();
    b = rand_block();
    fill_ref(a);
    ref_a = ref_w;
    fill_ref(b);
    ref_b = ref_w;
    bus.blk_i = a;
    bus.blk_valid_i = 1'b1;
    bus.w_ready_i = 1'b1;
    idx = 0; gap = 0; other = 0; nacc = 0; n = 0;
    while (idx < 128 && n < 400) begin
      pend = bus.blk_valid_i && bus.blk_ready_o;
`ifndef SHA_SCHED_PREFETCH_EN
      if (bus.w_valid_o && bus.blk_valid_i) chk("ready_in_run", 32'(bus.blk_ready_o), 32'd0);
`endif
      if (bus.w_valid_o) begin
        chk("b2b_w_o", bus.w_o, idx < 64 ? ref_a[idx % 64] : ref_b[idx % 64]);
        chk("b2b_round", 32'(bus.round_o), 32'(idx % 64));
        chk("b2b_last", 32'(bus.last_o), 32'(idx % 64 == 63));
        idx++;
      end else if (idx == 64) gap++;
      else if (idx > 0) other++;
      tick();
      n++;
      if (pend) begin
        nacc++;
        if (nacc == 1) bus.blk_i = b;
        else bus.blk_valid_i = 1'b0;
      end
    end
    chk("b2b_words", 32'(idx), 32'd128);
`ifdef SHA_SCHED_PREFETCH_EN
    chk("b2b_gap", 32'(gap), 32'd0);
`else
    chk("b2b_gap", 32'(gap), 32'd1);
`endif
    chk("b2b_other_gaps", 32'(other), 32'd0);
    chk("b2b_accepts", 32'(nacc), 32'd2);
    bus.blk_valid_i = 1'b0;
    bus.w_ready_i = 1'b0;
    chk("b2b_no_extra", 32'(bus.w_valid_o), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha_schedule_ctrl.md
SHA_SCHEDULE_CTRL -- requirements
Module: sha_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 64, giving the number of schedule words emitted per block (legal range 16..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port blk_valid_i, input, 1 bit: a message block is offered.
REQ-005 The block SHALL have port blk_ready_o, output, 1 bit: the block can be accepted.
REQ-006 The block SHALL have port blk_i, input, 16x32 bits: blk_i[i] = message word W[i].
REQ-007 The block SHALL have port w_valid_o, output, 1 bit: w_o and round_o are valid.
REQ-008 The block SHALL have port w_ready_i, input, 1 bit: the consumer takes the current word.
REQ-009 The block SHALL have port w_o, output, 32 bits: schedule word W[round_o].
REQ-010 The block SHALL have port round_o, output, 6 bits: index t of the current word.
REQ-011 The block SHALL have port last_o, output, 1 bit: the current word is W[NUM_WORDS-1].

Function
REQ-012 A block SHALL be accepted on a cycle where blk_valid_i & blk_ready_o are both 1; a word SHALL be transferred on a cycle where w_valid_o & w_ready_i are both 1.
REQ-013 The FSM SHALL have the states IDLE and RUN.
- IDLE: blk_ready_o=1, w_valid_o=0.
- RUN: w_valid_o=1.
REQ-014 On acceptance in IDLE, the block SHALL load history h[i]=blk_i[15-i] (h[15] oldest), set the counter to 0 and go to RUN; the first word SHALL be valid on the next cycle (latency 1).
REQ-015 In RUN, w_o SHALL equal h[15] and round_o SHALL equal the counter; last_o SHALL be 1 only when the counter is NUM_WORDS-1.
REQ-016 On each transfer, history SHALL shift (h[i]<=h[i-1] for i=1..15) and h[0] SHALL take the output of one expansion round on the pre-shift h; the counter SHALL increment.
REQ-017 When w_ready_i=0, h, the counter, w_o, round_o and last_o SHALL hold unchanged.
REQ-018 A transfer with last_o=1 SHALL return the FSM to IDLE, except as set by REQ-024.
REQ-019 Expansion arithmetic SHALL be SHA-256 σ0/σ1 with 32-bit modulo-2^32 addition; carries SHALL be discarded.
REQ-020 The counter SHALL be 6 bits wide and SHALL never wrap within a block.

Reset
REQ-021 While rst=1, the block SHALL hold:
- state IDLE;
- h and the counter at 0;
- w_valid_o=0, last_o=0, round_o=0, w_o=0;
- blk_ready_o=0.
REQ-022 After rst deasserts, blk_ready_o SHALL be 1 from the first clock edge.
REQ-023 Reset asserted mid-block SHALL abort the block immediately; no further words of that block SHALL be emitted.

Configuration
REQ-024 With macro SHA_SCHED_PREFETCH_EN defined, the block SHALL include a one-entry pending-block buffer:
- blk_ready_o=1 in RUN while the buffer is empty;
- on the last transfer with the buffer full, the buffer SHALL load into h, the counter SHALL reset to 0 and the FSM SHALL stay in RUN (zero-bubble back-to-back);
- an acceptance in the same cycle as the last transfer with the buffer empty SHALL load h directly.
REQ-025 Without SHA_SCHED_PREFETCH_EN, blk_ready_o SHALL be 0 in RUN, and at least one IDLE cycle SHALL separate consecutive blocks.

Structure
REQ-026 Package sha_pkg SHALL hold the word_t (32-bit) and block_t (16 x word_t) typedefs and the SHA_BLOCK_WORDS=16 constant.
REQ-027 The block SHALL instantiate the existing combinational sub-module sha_message_expander_round (history in, new word out) exactly once.

Verification
REQ-028 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready_i=1 → 64 consecutive valid words; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; last_o=1 only at round_o=63.
REQ-029 Same block, w_ready_i toggled 1/0 every cycle → identical word sequence, outputs held on stall cycles, 127 cycles from first valid to last transfer.
REQ-030 rst pulsed at round_o=20 → w_valid_o=0 asynchronously; a fresh block afterwards restarts at round_o=0 with a correct W0.
REQ-031 Two blocks offered back-to-back → with SHA_SCHED_PREFETCH_EN, round_o=63 is followed directly by round_o=0 of block 2; without it, one IDLE cycle separates the blocks.
REQ-032 NUM_WORDS=16 → exactly W0..W15 emitted unchanged and last_o=1 at round_o=15.
REQ-033 blk_valid_i held high in RUN without the macro → blk_ready_o=0 throughout and no block is lost or duplicated.
